// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bus of the SRAM controller: one 32-bit
// load or store request and the ready/read_data response.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two timed half-word accesses to an
// asynchronous 16-bit SRAM, holding ready low so the pipeline freezes.
//
// state | meaning
// IDLE  | no access in flight; a request is accepted on the next edge
// LOW   | half-word 0 access, held ACCESS_CYCLES cycles
// HIGH  | half-word 1 access, held ACCESS_CYCLES cycles
// DONE  | one-cycle completion; ready high, read_data valid
module sram_controller #(
  parameter int unsigned DATA_BASE     = 1024,
  parameter int          SRAM_ADDR_W   = 18,
  parameter int          ACCESS_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE = 32'(DATA_BASE);
  localparam logic [3:0]  LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  // Byte address to half-word-pair index; upper bits drop so accesses wrap.
  function automatic logic [SRAM_ADDR_W-2:0] word_of(input logic [31:0] a);
    return (SRAM_ADDR_W-1)'((a - BASE) >> 2);
  endfunction

  assign bus.ready = ((state == IDLE) && !(bus.rd_en || bus.wr_en)) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      op_wr         <= 1'b0;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      bus.read_data <= 32'd0;
      sram_addr     <= '0;
      sram_dq_out   <= 16'd0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_en || bus.rd_en) begin
            op_wr       <= bus.wr_en;
            addr_q      <= bus.address;
            data_q      <= bus.write_data;
            cnt         <= 4'd0;
            state       <= LOW;
            // Pad outputs are registered, so they are set up for LOW here.
            sram_addr   <= {word_of(bus.address), 1'b0};
            sram_we_n   <= ~bus.wr_en;
            sram_dq_oe  <= bus.wr_en;
            sram_dq_out <= bus.wr_en ? bus.write_data[15:0] : 16'd0;
          end
        end
        LOW: begin
          if (cnt != LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            cnt         <= 4'd0;
            state       <= HIGH;
            sram_addr   <= {word_of(addr_q), 1'b1};
            sram_dq_out <= op_wr ? data_q[31:16] : 16'd0;
            if (!op_wr) bus.read_data[15:0] <= sram_dq_in;
          end
        end
        HIGH: begin
          if (cnt != LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            cnt         <= 4'd0;
            state       <= DONE;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= 16'd0;
            if (!op_wr) bus.read_data[31:16] <= sram_dq_in;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: table of load/store vectors checked
// cycle by cycle against a small SRAM model, plus back-to-back and reset cases.
module tb_sram_controller;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  sram_controller_if bus();

  sram_controller #(
    .DATA_BASE(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(N)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Small SRAM model indexed by the low address bits.
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr[7:0]];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = wdata;
    #1;
    chk("ready_cycle0", 32'(bus.ready), 32'd0);
  endtask

  // Checks cycles 1..2N+1 of an accepted access; ends inside the DONE cycle.
  task automatic track(input logic wr, input logic [17:0] base, input logic [31:0] wdata,
                       input logic [31:0] exp_rd);
    for (int c = 1; c <= 2*N+1; c++) begin
      @(posedge clk); #1;
      if (c <= 2*N) begin
        chk("ready_busy", 32'(bus.ready), 32'd0);
        chk("we_n_busy", 32'(sram_we_n), 32'(!wr));
        chk("oe_busy", 32'(sram_dq_oe), 32'(wr));
        chk("addr_busy", 32'(sram_addr), (c <= N) ? 32'(base) : 32'(base) + 32'd1);
        chk("dq_out_busy", 32'(sram_dq_out),
            !wr ? 32'd0 : (c <= N) ? 32'(wdata[15:0]) : 32'(wdata[31:16]));
      end else begin
        chk("ready_done", 32'(bus.ready), 32'd1);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("oe_done", 32'(sram_dq_oe), 32'd0);
        chk("dq_out_done", 32'(sram_dq_out), 32'd0);
        chk("addr_done_hold", 32'(sram_addr), 32'(base) + 32'd1);
        chk("read_data_done", bus.read_data, exp_rd);
      end
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] base;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 18'd0,       32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,   32'h0,        18'd0,       32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1028,   32'h12345678, 18'd2,       32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'd1028,   32'h0,        18'd2,       32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1032,   32'hCAFEF00D, 18'd4,       32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd1032,   32'h0,        18'd4,       32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd525312, 32'h0,        18'd0,       32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b0, 32'd1020,   32'h0,        18'h3FFFE,   32'h0};

    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", bus.read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      exp = vecs[i].wr ? last_rd : vecs[i].exp_rd;
      @(posedge clk); #1;
      start_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      track(vecs[i].wr, vecs[i].base, vecs[i].wdata, exp);
      last_rd = exp;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", 32'(bus.ready), 32'd1);
      chk("idle_read_data_hold", bus.read_data, last_rd);
    end

    // Back-to-back: load then store presented in the DONE cycle.
    @(posedge clk); #1;
    start_req(1'b1, 1'b0, 32'd1028, 32'h0);
    track(1'b0, 18'd2, 32'h0, 32'h12345678);
    bus.rd_en = 1'b0; bus.wr_en = 1'b1; bus.address = 32'd1036; bus.write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("b2b_ready_cycle12", 32'(bus.ready), 32'd0);
    chk("b2b_we_n_cycle12", 32'(sram_we_n), 32'd1);
    track(1'b1, 18'd6, 32'h0BADF00D, 32'h12345678);
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    start_req(1'b1, 1'b0, 32'd1036, 32'h0);
    track(1'b0, 18'd6, 32'h0, 32'h0BADF00D);
    bus.rd_en = 1'b0;

    // Reset in cycle 6 of a write.
    @(posedge clk); #1;
    start_req(1'b0, 1'b1, 32'd1040, 32'h55AA33CC);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("rstmid_we_n_low", 32'(sram_we_n), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid_addr", 32'(sram_addr), 32'd0);
    chk("rstmid_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rstmid_read_data", bus.read_data, 32'd0);
    chk("rstmid_ready_req", 32'(bus.ready), 32'd0);
    rst = 1'b0; bus.wr_en = 1'b0;
    #1;
    chk("rstmid_ready_noreq", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    chk("rstmid_idle_ready", 32'(bus.ready), 32'd1);
    chk("rstmid_idle_we_n", 32'(sram_we_n), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the EXE/MEM pipeline register and an off-chip 16-bit asynchronous SRAM. It turns one 32-bit load or store from the MEM stage into two half-word SRAM accesses. It holds `ready` low for the duration so the top level can freeze every pipeline stage. Each accepted access completes in a fixed, parameterised number of cycles.

## Interface
Parameters:
- `DATA_BASE`, 1024: byte address that maps to SRAM word 0.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.
- `ACCESS_CYCLES`, 5: cycles held per half-word access, legal range 1..15.

Ports:
- `clk`  in  1  single clock; every state change on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  load request; held stable until `ready`.
- `wr_en`  in  1  store request; held stable until `ready`.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result, registered.
- `ready`  out  1  high means no access is pending; low means freeze the pipeline.
- `sram_addr`  out  SRAM_ADDR_W  half-word address.
- `sram_dq_out`  out  16  write data driven to the pads.
- `sram_dq_in`  in  16  read data sampled from the pads.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_we_n`  out  1  active-low SRAM write enable.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A 4-bit cycle counter `cnt` runs inside LOW and HIGH.
- In IDLE with `wr_en|rd_en` asserted:
  - latch `address`, `write_data` and op; op is write if `wr_en`, and `wr_en` wins when both are high;
  - go to LOW, clear `cnt`.
- LOW and HIGH:
  - stay while `cnt != ACCESS_CYCLES-1`, incrementing `cnt`;
  - on the last cycle, clear `cnt`; LOW goes to HIGH, HIGH goes to DONE.
- DONE: always goes to IDLE next cycle.
- Address mapping:
  - `eff = latched_address - DATA_BASE`, 32-bit wrapping subtract;
  - `word = eff[SRAM_ADDR_W:2]`;
  - `sram_addr = {word, 0}` in LOW and `{word, 1}` in HIGH;
  - upper bits are discarded, so addresses wrap modulo SRAM size with no error;
  - `eff[1:0]` is ignored.
- Write op:
  - `sram_dq_oe=1` and `sram_we_n=0` for every LOW and HIGH cycle;
  - `sram_dq_out` = latched data [15:0] in LOW, [31:16] in HIGH.
- Read op:
  - `sram_we_n=1`, `sram_dq_oe=0`;
  - on the last cycle of LOW, `read_data[15:0] <= sram_dq_in`;
  - on the last cycle of HIGH, `read_data[31:16] <= sram_dq_in`.
- `read_data` is not modified by writes or in IDLE/DONE; it holds the last load result.
- In IDLE and DONE: `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr` holds its last value, `sram_dq_out=0`.
- `ready` is combinational: `(IDLE & ~(rd_en|wr_en)) | DONE`.
- Requests arriving in LOW, HIGH or DONE are not accepted. A request still present when IDLE is re-entered is treated as new, so the pipeline must have advanced on the DONE edge.

## Timing
- Reset values:
  - state IDLE, `cnt=0`;
  - `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`;
  - `ready=1` whenever no request is present.
- Let N = `ACCESS_CYCLES`, and cycle 0 = the IDLE cycle where the request is accepted:
  - LOW occupies cycles 1..N;
  - HIGH occupies cycles N+1..2N;
  - DONE occupies cycle 2N+1.
- `ready` is low for cycles 0..2N (2N+1 cycles) and high in cycle 2N+1.
- `read_data` is valid from cycle 2N+1 and is captured by the MEM/WB register on the DONE edge.
- Back-to-back: next request accepted at cycle 2N+2 at the earliest, so steady state is one access per 2N+2 cycles.
- `rst` at any point, including mid-access: next edge returns to reset values. A partial write may leave one half-word in SRAM; that is accepted behaviour.
- N=1 is legal: LOW and HIGH are one cycle each, and DONE falls at cycle 3.

## Test plan
- Reset then idle, no requests: `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
- Store 0xDEADBEEF to address 1024 (N=5): `sram_we_n` low cycles 1..10; `sram_addr` 0 with dq 0xBEEF, then 1 with dq 0xDEAD; `ready` low cycles 0..10, high cycle 11.
- Load from 1024 with an SRAM model holding 0xBEEF/0xDEAD: `read_data=0xDEADBEEF` at cycle 11.
- Load from 1028: `sram_addr` 2 then 3.
- Both `rd_en` and `wr_en` high: a write is performed.
- Back-to-back load then store: second access accepted at cycle 12, with `ready` low again in cycle 12.
- `rst` at cycle 6 of a write: state IDLE and `sram_we_n=1` next cycle, `ready` follows the request. Address 1024+4·2^17 maps to `sram_addr` 0 (wrap).
